axi_slave_mem: RTL



---
 rtl/axi_slave_mem.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_mem.sv
// AXI3 slave memory model: independent write and read FSMs over one word array.
// Latency: AW->WREADY 1 cycle, last W->BVALID 1 cycle, AR->first R beat 1 cycle.
// Backpressure: BVALID and RDATA/RRESP/RID/RLAST held stable until BREADY/RREADY; one burst in flight per direction.
module axi_slave_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 9,
    parameter int DEPTH  = 1024
) (
    input  logic                dut_clock,
    input  logic                dut_reset,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [ID_W-1:0]     AWID,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [ID_W-1:0]     ARID,
    input  logic [3:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [ID_W-1:0]     RID,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF;
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Size and sub-word address bits carry no meaning: every beat is a full aligned word.
    logic unused_ok;
    assign unused_ok = ^{AWSIZE, ARSIZE, AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

    function automatic logic [IDX_W-1:0] step(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + 1'b1;
    endfunction

    // Out-of-range beats outrank bad burst types.
    function automatic logic [1:0] resp(input logic dec, input logic slv);
        return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
    endfunction

    // ---------------- write path ----------------
    w_state_t          w_state_q, w_state_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d, w_burst_q, w_burst_d;
    logic [IDX_W-1:0]  w_idx_q, w_idx_d;
    logic [3:0]        w_cnt_q, w_cnt_d, w_len_q, w_len_d;
    logic              w_dec_q, w_dec_d, w_slv_q, w_slv_d;
    logic              w_in_range, w_we, w_last_beat, w_dec_n, w_slv_n;

    // Write FSM next-state: latch AW, consume beats counting against AWLEN, then hold B.
    always_comb begin
        w_state_d = w_state_q;  awready_d = awready_q;  wready_d = wready_q;
        bvalid_d  = bvalid_q;   bid_d     = bid_q;      bresp_d  = bresp_q;
        w_idx_d   = w_idx_q;    w_cnt_d   = w_cnt_q;    w_len_d  = w_len_q;
        w_burst_d = w_burst_q;  w_dec_d   = w_dec_q;    w_slv_d  = w_slv_q;
        w_in_range  = w_idx_q < DEPTH_IDX;
        w_last_beat = w_cnt_q == w_len_q;
        w_dec_n     = w_dec_q | ~w_in_range;
        // WLAST must match the beat count exactly; the count alone ends the burst.
        w_slv_n     = w_slv_q | (WLAST != w_last_beat);
        w_we        = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    w_state_d = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = AWID;
                    w_idx_d   = AWADDR[ADDR_W-1:OFF];
                    w_len_d   = AWLEN;
                    w_burst_d = AWBURST;
                    w_cnt_d   = 4'd0;
                    w_dec_d   = 1'b0;
                    w_slv_d   = (AWBURST != BURST_FIXED) && (AWBURST != BURST_INCR);
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    w_we    = w_in_range;
                    w_dec_d = w_dec_n;
                    w_slv_d = w_slv_n;
                    w_idx_d = step(w_idx_q, w_burst_q);
                    w_cnt_d = w_cnt_q + 4'd1;
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = resp(w_dec_n, w_slv_n);
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state and registered outputs.
    always_ff @(posedge dut_clock) begin
        if (dut_reset) begin
            w_state_q <= W_IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
            bid_q     <= '0;     bresp_q   <= '0;   w_idx_q  <= '0;   w_cnt_q  <= '0;
            w_len_q   <= '0;     w_burst_q <= '0;   w_dec_q  <= 1'b0; w_slv_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
            bid_q     <= bid_d;     bresp_q   <= bresp_d;   w_idx_q  <= w_idx_d;  w_cnt_q  <= w_cnt_d;
            w_len_q   <= w_len_d;   w_burst_q <= w_burst_d; w_dec_q  <= w_dec_d;  w_slv_q  <= w_slv_d;
        end
    end

    // Byte-strobed memory write; contents are deliberately never cleared.
    always_ff @(posedge dut_clock) begin
        if (w_we && !dut_reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_idx_q[MEM_AW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_word;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [1:0]        rresp_q, rresp_d, r_burst_q, r_burst_d;
    logic [IDX_W-1:0]  r_idx_q, r_idx_d, rd_idx;
    logic [3:0]        r_cnt_q, r_cnt_d, r_len_q, r_len_d;
    logic              r_bad_q, r_bad_d, rd_in_range, ar_bad;

    // Read FSM next-state: each beat is fetched when the previous one is accepted,
    // so a same-cycle write to that word is not yet visible.
    always_comb begin
        r_state_d = r_state_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
        rdata_d   = rdata_q;   rid_d     = rid_q;     rresp_d  = rresp_q;  r_idx_d = r_idx_q;
        r_cnt_d   = r_cnt_q;   r_len_d   = r_len_q;   r_burst_d = r_burst_q; r_bad_d = r_bad_q;
        rd_idx      = (r_state_q == R_IDLE) ? ARADDR[ADDR_W-1:OFF] : r_idx_q;
        rd_in_range = rd_idx < DEPTH_IDX;
        rd_word     = rd_in_range ? mem[rd_idx[MEM_AW-1:0]] : '0;
        ar_bad      = (ARBURST != BURST_FIXED) && (ARBURST != BURST_INCR);
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = ARID;
                    rdata_d   = rd_word;
                    rresp_d   = resp(~rd_in_range, ar_bad);
                    rlast_d   = ARLEN == 4'd0;
                    r_idx_d   = step(rd_idx, ARBURST);
                    r_cnt_d   = 4'd0;
                    r_len_d   = ARLEN;
                    r_burst_d = ARBURST;
                    r_bad_d   = ar_bad;
                end
            end
            R_DATA: begin
                if (RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                        rresp_d = resp(~rd_in_range, r_bad_q);
                        rlast_d = (r_cnt_q + 4'd1) == r_len_q;
                        r_cnt_d = r_cnt_q + 4'd1;
                        r_idx_d = step(r_idx_q, r_burst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge dut_clock) begin
        if (dut_reset) begin
            r_state_q <= R_IDLE; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rdata_q   <= '0;     rid_q     <= '0;   rresp_q  <= '0;   r_idx_q <= '0;
            r_cnt_q   <= '0;     r_len_q   <= '0;   r_burst_q <= '0;  r_bad_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
            rdata_q   <= rdata_d;   rid_q     <= rid_d;     rresp_q  <= rresp_d;  r_idx_q <= r_idx_d;
            r_cnt_q   <= r_cnt_d;   r_len_q   <= r_len_d;   r_burst_q <= r_burst_d; r_bad_q <= r_bad_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RID     = rid_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;

endmodule
